// File: rtl/sakebi_pkg.sv
// Shared constants for the sakebi FIFO write-side blocks.
// Holds the arbiter state encoding, default sizes and a width helper.
package sakebi_pkg;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_XFER = 1'b1;

    localparam int DEF_MAX_LEN = 1518;
    localparam int DEF_DATA_W  = 8;

    // Index width for an n-entry vector, never below one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sakebi_rr_pick.sv
// Round-robin picker: returns the first set request strictly after `last`,
// wrapping modulo N, as a one-hot vector (all zero when nothing requests).
module sakebi_rr_pick
    import sakebi_pkg::*;
#(
    parameter int N     = 4,
    parameter int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last,
    output logic [N-1:0]     pick
);

    logic [IDX_W-1:0] idx;
    logic             found;

    // Walking the rotated order last+1 .. last+N is the rotate,
    // priority-encode and rotate-back done in one pass.
    always_comb begin
        // NOTE: every variable gets a default before the loop so no path leaves it unassigned (no latch).
        pick  = '0;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N; i++) begin
            idx = IDX_W'((int'(last) + i) % N);
            if (!found && req[idx]) begin
                pick[idx] = 1'b1;
                found     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/sakebi_fifo_wr_arbiter.sv
// Frame-atomic round-robin arbiter sharing one FIFO write port among N_SRC
// byte sources, with a MAX_LEN watchdog that truncates runaway frames.
module sakebi_fifo_wr_arbiter
    import sakebi_pkg::*;
#(
    parameter int N_SRC   = 4,
    parameter int DATA_W  = DEF_DATA_W,
    parameter int MAX_LEN = DEF_MAX_LEN,
    parameter int LEN_W   = 11
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic [N_SRC-1:0]        i_src_valid,
    input  logic [N_SRC*DATA_W-1:0] i_src_data,
    input  logic [N_SRC-1:0]        i_src_last,
    output logic [N_SRC-1:0]        o_src_ready,
    input  logic                    i_fifo_ready,
    output logic                    o_fifo_wr_en,
    output logic [DATA_W-1:0]       o_fifo_wr_data,
    output logic                    o_busy,
    output logic [N_SRC-1:0]        o_grant,
    output logic                    o_trunc,
    output logic [15:0]             o_frame_cnt
);

    localparam int IDX_W = idx_w(N_SRC);

    logic              state;
    logic [N_SRC-1:0]  grant;
    logic [IDX_W-1:0]  last_grant;
    logic [LEN_W-1:0]  byte_cnt;
    logic              trunc;
    logic [15:0]       frame_cnt;

    logic [N_SRC-1:0]  pick;
    logic [IDX_W-1:0]  grant_idx;
    logic [DATA_W-1:0] sel_data;
    logic              sel_valid;
    logic              sel_last;
    logic              xfer;
    logic [LEN_W-1:0]  cnt_next;
    logic              hit_max;
    logic              rel;

    sakebi_rr_pick #(
        .N     (N_SRC),
        .IDX_W (IDX_W)
    ) u_pick (
        .req  (i_src_valid),
        .last (last_grant),
        .pick (pick)
    );

    // Grant is one-hot, so an AND-OR mux suffices for data and index.
    always_comb begin
        grant_idx = '0;
        sel_data  = '0;
        for (int k = 0; k < N_SRC; k++) begin
            if (grant[k]) begin
                grant_idx = IDX_W'(k);
                sel_data  = i_src_data[k*DATA_W +: DATA_W];
            end
        end
    end

    assign sel_valid = |(i_src_valid & grant);
    assign sel_last  = |(i_src_last & grant);
    assign xfer      = (state == ST_XFER) && sel_valid && i_fifo_ready;
    assign cnt_next  = byte_cnt + LEN_W'(1);
    assign hit_max   = (cnt_next == LEN_W'(MAX_LEN));
    assign rel       = xfer && (sel_last || hit_max);

    assign o_src_ready    = (state == ST_XFER) ? (grant & {N_SRC{i_fifo_ready}}) : '0;
    assign o_fifo_wr_en   = xfer;
    assign o_fifo_wr_data = sel_data;
    assign o_busy         = (state == ST_XFER);
    assign o_grant        = grant;
    assign o_trunc        = trunc;
    assign o_frame_cnt    = frame_cnt;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state      <= ST_IDLE;
            grant      <= '0;
            last_grant <= IDX_W'(N_SRC - 1);
            byte_cnt   <= '0;
            trunc      <= 1'b0;
            frame_cnt  <= '0;
        end else begin
            trunc <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (|i_src_valid) begin
                        grant <= pick;
                        state <= ST_XFER;
                    end
                end
                ST_XFER: begin
                    if (xfer) begin
                        if (rel) begin
                            state      <= ST_IDLE;
                            grant      <= '0;
                            last_grant <= grant_idx;
                            byte_cnt   <= '0;
                            frame_cnt  <= frame_cnt + 16'd1;
                            // Last on the MAX_LEN byte is an ordinary end of frame.
                            trunc      <= hit_max && !sel_last;
                        end else begin
                            byte_cnt <= cnt_next;
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sakebi_fifo_wr_arbiter.sv
// Directed bench for sakebi_fifo_wr_arbiter (MAX_LEN=4): per-source byte
// queues feed the DUT; logged FIFO writes and grants are compared to hand-written lists.
module tb_sakebi_fifo_wr_arbiter;

    localparam int N = 4;

    logic         clk = 1'b0;
    logic         i_rst;
    logic [N-1:0] i_src_valid;
    logic [N*8-1:0] i_src_data;
    logic [N-1:0] i_src_last;
    logic [N-1:0] o_src_ready;
    logic         i_fifo_ready;
    logic         o_fifo_wr_en;
    logic [7:0]   o_fifo_wr_data;
    logic         o_busy;
    logic [N-1:0] o_grant;
    logic         o_trunc;
    logic [15:0]  o_frame_cnt;

    always #5 clk = ~clk;

    sakebi_fifo_wr_arbiter #(
        .N_SRC   (N),
        .DATA_W  (8),
        .MAX_LEN (4),
        .LEN_W   (11)
    ) dut (
        .i_clk          (clk),
        .i_rst          (i_rst),
        .i_src_valid    (i_src_valid),
        .i_src_data     (i_src_data),
        .i_src_last     (i_src_last),
        .o_src_ready    (o_src_ready),
        .i_fifo_ready   (i_fifo_ready),
        .o_fifo_wr_en   (o_fifo_wr_en),
        .o_fifo_wr_data (o_fifo_wr_data),
        .o_busy         (o_busy),
        .o_grant        (o_grant),
        .o_trunc        (o_trunc),
        .o_frame_cnt    (o_frame_cnt)
    );

    int         n_pass = 0;
    int         n_total = 0;
    int         cyc = 0;
    int         trunc_cnt = 0;
    logic       rst = 1'b1;
    logic       fifo_rdy = 1'b1;
    logic [7:0] q_data [N][$];
    logic       q_last [N][$];
    logic [7:0] wr_log[$];
    logic [7:0] exp_q[$];
    int         wr_cyc[$];
    logic [3:0] grant_log[$];
    logic [3:0] exp_g[$];
    logic [3:0] prev_grant = '0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] want);
        n_total++;
        if (act === want) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, want);
    endtask

    task automatic push_beat(input int k, input logic [7:0] d, input logic l);
        q_data[k].push_back(d);
        q_last[k].push_back(l);
    endtask

    task automatic flush_all();
        for (int k = 0; k < N; k++) begin
            q_data[k].delete();
            q_last[k].delete();
        end
    endtask

    task automatic clear_logs();
        wr_log.delete();
        wr_cyc.delete();
        grant_log.delete();
        trunc_cnt = 0;
    endtask

    // Drive on the falling edge, sample 1 ns later, pop on handshake.
    task automatic cycle();
        @(negedge clk);
        i_rst        = rst;
        i_fifo_ready = fifo_rdy;
        for (int k = 0; k < N; k++) begin
            if (q_data[k].size() > 0) begin
                i_src_valid[k]        = 1'b1;
                i_src_data[k*8 +: 8]  = q_data[k][0];
                i_src_last[k]         = q_last[k][0];
            end else begin
                i_src_valid[k]        = 1'b0;
                i_src_data[k*8 +: 8]  = 8'h00;
                i_src_last[k]         = 1'b0;
            end
        end
        #1;
        cyc++;
        if (o_fifo_wr_en) begin
            wr_log.push_back(o_fifo_wr_data);
            wr_cyc.push_back(cyc);
        end
        if (o_trunc) trunc_cnt++;
        if (o_grant != 4'b0 && o_grant != prev_grant) grant_log.push_back(o_grant);
        prev_grant = o_grant;
        for (int k = 0; k < N; k++) begin
            if (o_src_ready[k] && i_src_valid[k]) begin
                void'(q_data[k].pop_front());
                void'(q_last[k].pop_front());
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic check_bytes(input string tag);
        logic [7:0] act;
        check({tag, "_nbytes"}, 32'(wr_log.size()), 32'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++) begin
            act = (i < wr_log.size()) ? wr_log[i] : 8'hxx;
            check($sformatf("%s_byte%0d", tag, i), 32'(act), 32'(exp_q[i]));
        end
    endtask

    task automatic check_grants(input string tag);
        logic [3:0] act;
        check({tag, "_ngrants"}, 32'(grant_log.size()), 32'(exp_g.size()));
        for (int i = 0; i < exp_g.size(); i++) begin
            act = (i < grant_log.size()) ? grant_log[i] : 4'hx;
            check($sformatf("%s_grant%0d", tag, i), 32'(act), 32'(exp_g[i]));
        end
    endtask

    initial begin
        i_rst        = 1'b1;
        i_fifo_ready = 1'b1;
        i_src_valid  = '0;
        i_src_data   = '0;
        i_src_last   = '0;

        // Reset state
        run(2);
        rst = 1'b0;
        check("rst_grant", 32'(o_grant), 32'h0);
        check("rst_busy", 32'(o_busy), 32'h0);
        check("rst_trunc", 32'(o_trunc), 32'h0);
        check("rst_frame_cnt", 32'(o_frame_cnt), 32'h0);
        check("rst_wr_en", 32'(o_fifo_wr_en), 32'h0);
        check("rst_ready", 32'(o_src_ready), 32'h0);

        // Single source, 3-byte frame
        clear_logs();
        push_beat(0, 8'h55, 1'b0);
        push_beat(0, 8'hAA, 1'b0);
        push_beat(0, 8'h11, 1'b1);
        cycle();
        check("t1_req_grant", 32'(o_grant), 32'h0);
        check("t1_req_wr_en", 32'(o_fifo_wr_en), 32'h0);
        cycle();
        check("t1_grant", 32'(o_grant), 32'h1);
        check("t1_ready", 32'(o_src_ready), 32'h1);
        run(4);
        exp_q = '{8'h55, 8'hAA, 8'h11};
        check_bytes("t1");
        check("t1_idle_grant", 32'(o_grant), 32'h0);
        check("t1_idle_busy", 32'(o_busy), 32'h0);
        check("t1_frame_cnt", 32'(o_frame_cnt), 32'h1);

        // Contention after a fresh reset: order 0,1,2,3,0
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        clear_logs();
        for (int k = 0; k < N; k++) begin
            push_beat(k, 8'(8'h10 * (k + 1)), 1'b0);
            push_beat(k, 8'(8'h10 * (k + 1) + 1), 1'b1);
        end
        push_beat(0, 8'h50, 1'b0);
        push_beat(0, 8'h51, 1'b1);
        run(18);
        exp_g = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        check_grants("t2");
        exp_q = '{8'h10, 8'h11, 8'h20, 8'h21, 8'h30, 8'h31, 8'h40, 8'h41, 8'h50, 8'h51};
        check_bytes("t2");
        for (int i = 1; i < 9; i += 2) begin
            check($sformatf("t2_gap%0d", i), 32'((i + 1 < wr_cyc.size()) ? wr_cyc[i + 1] - wr_cyc[i] : 0), 32'd2);
        end
        check("t2_frame_cnt", 32'(o_frame_cnt), 32'd5);

        // Backpressure mid-frame of src1 (4 bytes, last coincides with MAX_LEN)
        clear_logs();
        push_beat(1, 8'h61, 1'b0);
        push_beat(1, 8'h62, 1'b0);
        push_beat(1, 8'h63, 1'b0);
        push_beat(1, 8'h64, 1'b1);
        run(3);
        fifo_rdy = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cycle();
            check($sformatf("t3_stall%0d_wr_en", i), 32'(o_fifo_wr_en), 32'h0);
            check($sformatf("t3_stall%0d_ready", i), 32'(o_src_ready), 32'h0);
            check($sformatf("t3_stall%0d_grant", i), 32'(o_grant), 32'h2);
        end
        fifo_rdy = 1'b1;
        run(4);
        exp_q = '{8'h61, 8'h62, 8'h63, 8'h64};
        check_bytes("t3");
        check("t3_trunc_cnt", 32'(trunc_cnt), 32'h0);
        check("t3_busy", 32'(o_busy), 32'h0);
        check("t3_frame_cnt", 32'(o_frame_cnt), 32'd6);

        // Watchdog: src2 streams 6 bytes without last
        clear_logs();
        for (int i = 0; i < 6; i++) push_beat(2, 8'(8'hC0 + i), 1'b0);
        cycle();
        push_beat(3, 8'hD3, 1'b1);
        push_beat(0, 8'hD0, 1'b1);
        run(4);
        check("t4_pre_trunc", 32'(trunc_cnt), 32'h0);
        cycle();
        check("t4_trunc", 32'(o_trunc), 32'h1);
        check("t4_busy", 32'(o_busy), 32'h0);
        q_data[2].delete();
        q_last[2].delete();
        push_beat(2, 8'hE2, 1'b1);
        run(8);
        exp_q = '{8'hC0, 8'hC1, 8'hC2, 8'hC3, 8'hD3, 8'hD0, 8'hE2};
        check_bytes("t4");
        exp_g = '{4'b0100, 4'b1000, 4'b0001, 4'b0100};
        check_grants("t4");
        check("t4_trunc_cnt", 32'(trunc_cnt), 32'h1);
        check("t4_frame_cnt", 32'(o_frame_cnt), 32'd10);

        // Last coincides with MAX_LEN on src0
        clear_logs();
        push_beat(0, 8'hF0, 1'b0);
        push_beat(0, 8'hF1, 1'b0);
        push_beat(0, 8'hF2, 1'b0);
        push_beat(0, 8'hF3, 1'b1);
        run(7);
        exp_q = '{8'hF0, 8'hF1, 8'hF2, 8'hF3};
        check_bytes("t5");
        check("t5_trunc_cnt", 32'(trunc_cnt), 32'h0);
        check("t5_frame_cnt", 32'(o_frame_cnt), 32'd11);

        // Reset during src3's second byte
        clear_logs();
        push_beat(3, 8'h31, 1'b0);
        push_beat(3, 8'h32, 1'b0);
        push_beat(3, 8'h33, 1'b1);
        run(2);
        check("t6_grant_pre", 32'(o_grant), 32'h8);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        flush_all();
        for (int k = 0; k < N; k++) push_beat(k, 8'(8'h70 + k), 1'b1);
        cycle();
        check("t6_grant", 32'(o_grant), 32'h0);
        check("t6_busy", 32'(o_busy), 32'h0);
        check("t6_trunc", 32'(o_trunc), 32'h0);
        check("t6_frame_cnt", 32'(o_frame_cnt), 32'h0);
        check("t6_wr_en", 32'(o_fifo_wr_en), 32'h0);
        check("t6_ready", 32'(o_src_ready), 32'h0);
        cycle();
        check("t6_first_pick", 32'(o_grant), 32'h1);
        check("t6_first_data", 32'(o_fifo_wr_data), 32'h70);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/sakebi_fifo_wr_arbiter.md
Name: sakebi_fifo_wr_arbiter

Overview:
- Frame-atomic round-robin arbiter that shares the single 8-bit write port of the sakebi async FIFO among N byte-stream sources.
- Sits entirely in the FIFO write-clock domain, between packet producers (e.g. TX frame builders) and the FIFO write side.
- Grants one source at a time, holds the grant until that source's last byte, and truncates runaway frames with a length watchdog.

Parameters:
- N_SRC, 4, number of requesting sources (2..8).
- DATA_W, 8, byte width; must match the FIFO data width.
- MAX_LEN, 1518, maximum bytes per grant before forced release.
- LEN_W, 11, width of the byte counter; must satisfy 2**LEN_W > MAX_LEN.

Ports:
- i_clk  in  1  write-side clock; same clock as the FIFO i_wr_clk.
- i_rst  in  1  reset; synchronous, active-high.
- i_src_valid  in  N_SRC  per-source byte valid.
- i_src_data  in  N_SRC*DATA_W  per-source byte; source k occupies bits [k*DATA_W +: DATA_W].
- i_src_last  in  N_SRC  per-source last-byte-of-frame flag, qualified by valid.
- o_src_ready  out  N_SRC  per-source ready; at most one bit high.
- i_fifo_ready  in  1  from FIFO o_wr_ready (not full).
- o_fifo_wr_en  out  1  to FIFO i_wr_en.
- o_fifo_wr_data  out  DATA_W  to FIFO i_wr_data.
- o_busy  out  1  high while a grant is held.
- o_grant  out  N_SRC  one-hot current grant; all zero when idle.
- o_trunc  out  1  one-cycle pulse when the watchdog forces a release.
- o_frame_cnt  out  16  completed-frame counter, including truncated frames; wraps.

Behaviour:
- Reset (i_rst high at a clock edge):
  - state IDLE; o_grant=0, o_busy=0, o_trunc=0, o_frame_cnt=0, byte count 0.
  - last-grant pointer = N_SRC-1, so source 0 has first priority.
  - o_src_ready=0 and o_fifo_wr_en=0, since both are combinational from state.
- Reset mid-frame aborts the grant with no further writes. FIFO contents are not the arbiter's concern.
- A transfer occurs on a cycle where the granted source's valid is high and i_fifo_ready is high.
- IDLE:
  - All outputs to sources and to the FIFO are low.
  - If any i_src_valid bit is set, select the first set bit searching upward from last_grant+1, modulo N_SRC.
  - Register that bit into o_grant and go to XFER.
  - Arbitration latency: 1 cycle. No byte is written in the request cycle.
- XFER, granted source g (all combinational):
  - o_src_ready[g] = i_fifo_ready; all other ready bits are 0.
  - o_fifo_wr_en = i_src_valid[g] & i_fifo_ready.
  - o_fifo_wr_data = i_src_data[g]; don't-care when wr_en is low.
- Byte count increments on each transfer.
- Release, evaluated on a transfer:
  - if i_src_last[g] = 1, or the post-increment count equals MAX_LEN, go to IDLE next cycle.
  - On release: last_grant <= g, count <= 0, o_frame_cnt += 1.
- Watchdog: if the count hits MAX_LEN without last, o_trunc pulses in the cycle after the final transfer. The source is then deasserted-ready and must drop the rest of its frame; that is its own responsibility.
- Last and MAX_LEN coinciding on the same byte counts as a normal release: o_trunc=0.
- There is always at least one IDLE cycle between grants, so back-to-back frames from different sources have a one-cycle gap.
- Source valid dropping mid-frame: the grant is held indefinitely, with no timeout on idle gaps.
- i_fifo_ready low (FIFO full): wr_en and ready stay low, the count is frozen, and no data is lost.
- Non-granted sources see ready=0 and must hold their data.
- Fairness: a source that just released has lowest priority on the next arbitration.

Decomposition:
- Package sakebi_pkg:
  - state encoding localparams: ST_IDLE=1'b0, ST_XFER=1'b1.
  - default MAX_LEN and default byte width constants.
- One natural sub-module: sakebi_rr_pick.
  - Combinational rotate / priority-encode / rotate-back.
  - Inputs: request vector and last-grant index. Output: one-hot pick.
  - Reusable by later arbiters.

Test Plan:
- Single source: src0 sends 0x55,0xAA,0x11 (last on 0x11) with fifo_ready=1 → o_grant=0001 one cycle after valid; wr_en high exactly 3 cycles with data 55,AA,11; o_frame_cnt=1; returns to IDLE.
- Contention: src0..src3 all valid with 2-byte frames → grant order 0,1,2,3,0; one idle cycle between frames; each FIFO byte matches its granted source.
- Backpressure: i_fifo_ready low for 5 cycles mid-frame of src1 → wr_en and o_src_ready[1] are 0 for those cycles; byte sequence is intact afterwards; count unchanged.
- Watchdog: MAX_LEN=4; src2 streams 6 bytes with no last → exactly 4 writes, o_trunc pulses once, o_busy falls; src2's next request is granted only after the other requesters.
- Coincident: MAX_LEN=4; src0's 4th byte has last=1 → release with o_trunc=0; o_frame_cnt increments by 1.
- Reset mid-frame: assert i_rst for 1 cycle during src3's 2nd byte → the next cycle has all outputs 0, o_frame_cnt=0; the next arbitration with all sources valid picks src0.
